// File: rtl/npx_pkg.sv
// Shared types and widths for the NeoPixel frame scheduler and its channel scaler.
package npx_pkg;

    localparam int unsigned CH_W = 8;
    localparam int unsigned PX_W = 3 * CH_W;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StSend,
        StLatch,
        StDone
    } state_e;

endpackage

// File: rtl/npx_scale.sv
// One-channel brightness scaler: (ch * scale) >> 8, purely combinational.
module npx_scale
    import npx_pkg::*;
(
    input  logic [CH_W-1:0] ch,
    input  logic [CH_W-1:0] scale,
    output logic [CH_W-1:0] scaled
);

    logic [2*CH_W-1:0] prod;

    assign prod   = {{CH_W{1'b0}}, ch} * {{CH_W{1'b0}}, scale};
    assign scaled = prod[2*CH_W-1:CH_W];

endmodule

// File: rtl/npx_frame_sched.sv
// Frame scheduler: reads NUM_LEDS pixel words, hands them to the serializer, then holds the latch gap.
// Define NPX_BRIGHTNESS_EN to scale every channel by the global brightness input.
module npx_frame_sched
    import npx_pkg::*;
#(
    parameter int unsigned NUM_LEDS     = 96,
    parameter int unsigned LATCH_CYCLES = 8192,
    parameter int unsigned AUTO_REFRESH = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [7:0]      rd_addr,
    input  logic [PX_W-1:0] rd_data,
    output logic [PX_W-1:0] px_data,
    output logic            px_valid,
    input  logic            px_ready,
    output logic            latch,
    input  logic [CH_W-1:0] brightness
);

    localparam int unsigned      CNT_W     = $clog2(LATCH_CYCLES + 1);
    localparam logic [7:0]       LAST_ADDR = 8'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LATCH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       addr_q, addr_d;
    logic [PX_W-1:0]  px_q, px_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PX_W-1:0]  px_in;

`ifdef NPX_BRIGHTNESS_EN
    for (genvar i = 0; i < 3; i++) begin : g_scale
        npx_scale u_scale (
            .ch     (rd_data[i*CH_W +: CH_W]),
            .scale  (brightness),
            .scaled (px_in[i*CH_W +: CH_W])
        );
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign px_in             = rd_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            px_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            px_q    <= px_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        px_d    = px_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    addr_d  = '0;
                end
            end
            StFetch: state_d = StWait;
            StWait: begin
                // RAM data lands exactly one cycle after the read strobe.
                px_d    = px_in;
                state_d = StSend;
            end
            StSend: begin
                if (px_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = StLatch;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = StFetch;
                    end
                end
            end
            StLatch: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (AUTO_REFRESH != 0 || start) begin
                    state_d = StFetch;
                    addr_d  = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign rd_en    = (state_q == StFetch);
    assign px_valid = (state_q == StSend);
    assign latch    = (state_q == StLatch);
    assign done     = (state_q == StDone);
    assign rd_addr  = addr_q;
    assign px_data  = px_q;

endmodule

// File: tb/tb_npx_frame_sched.sv
// Directed bench for npx_frame_sched: one frame-mode instance and one auto-refresh instance.
module tb_npx_frame_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        px_ready = 1'b0;
    logic [7:0]  brightness = 8'h80;
    logic        busy, done, rd_en, px_valid, latch;
    logic [7:0]  rd_addr;
    logic [23:0] rd_data, px_data;

    logic        start_a = 1'b0;
    logic        ready_a = 1'b1;
    logic        busy_a, done_a, rd_en_a, px_valid_a, latch_a;
    logic [7:0]  rd_addr_a;
    logic [23:0] rd_data_a, px_data_a;

    logic [23:0] ram [0:3];
    logic [23:0] exp_words [0:2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0, latch_cnt = 0, done_a_cnt = 0;
    logic [23:0] hs_q[$];
    int          hs_cyc[$];
    logic [7:0]  addr_q[$];

    npx_frame_sched #(.NUM_LEDS(3), .LATCH_CYCLES(16), .AUTO_REFRESH(0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .latch      (latch),
        .brightness (brightness)
    );

    npx_frame_sched #(.NUM_LEDS(3), .LATCH_CYCLES(16), .AUTO_REFRESH(1)) u_auto (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .busy       (busy_a),
        .done       (done_a),
        .rd_en      (rd_en_a),
        .rd_addr    (rd_addr_a),
        .rd_data    (rd_data_a),
        .px_data    (px_data_a),
        .px_valid   (px_valid_a),
        .px_ready   (ready_a),
        .latch      (latch_a),
        .brightness (brightness)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr[1:0]];
    always @(posedge clk) if (rd_en_a) rd_data_a <= ram[rd_addr_a[1:0]];

    always @(negedge clk) begin
        if (px_valid && px_ready) begin
            hs_q.push_back(px_data);
            hs_cyc.push_back(cyc);
        end
        if (rd_en) addr_q.push_back(rd_addr);
        if (done) done_cnt++;
        if (latch) latch_cnt++;
        if (done_a) done_a_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_mon();
        hs_q.delete();
        hs_cyc.delete();
        addr_q.delete();
        done_cnt  = 0;
        latch_cnt = 0;
    endtask

    // sel: 0 done, 1 px_valid, 2 latch, 3 done_a
    task automatic wait_sig(input int sel, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if ((sel == 0 && done) || (sel == 1 && px_valid) ||
                (sel == 2 && latch) || (sel == 3 && done_a)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total++;
        if ({busy, done, rd_en, px_valid, latch} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {busy, done, rd_en, px_valid, latch});
        end
        total++;
        if (rd_addr !== 8'h00) begin
            bad++;
            $display("FAIL reset_addr: got %h want 00", rd_addr);
        end
        total++;
        if (px_data !== 24'h0) begin
            bad++;
            $display("FAIL reset_px_data: got %h want 000000", px_data);
        end
        rst = 1'b0;
        repeat (2) step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_frame();
        bit ok;
        clear_mon();
        px_ready = 1'b1;
        pulse_start();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL frame_busy: got %b want 1", busy);
        end
        wait_sig(0, 200, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL frame_done_timeout: got %b want 1", ok);
        end
        step();
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL frame_end_state: got %b want 00", {busy, done});
        end
        total++;
        if (hs_q.size() !== 3) begin
            bad++;
            $display("FAIL frame_hs_count: got %0d want 3", hs_q.size());
        end
        for (int i = 0; i < 3 && i < hs_q.size(); i++) begin
            total++;
            if (hs_q[i] !== exp_words[i]) begin
                bad++;
                $display("FAIL frame_word%0d: got %h want %h", i, hs_q[i], exp_words[i]);
            end
            total++;
            if (i < addr_q.size() && addr_q[i] !== 8'(i)) begin
                bad++;
                $display("FAIL frame_addr%0d: got %h want %h", i, addr_q[i], 8'(i));
            end
        end
        for (int i = 1; i < 3 && i < hs_cyc.size(); i++) begin
            total++;
            if (hs_cyc[i] - hs_cyc[i-1] !== 3) begin
                bad++;
                $display("FAIL frame_latency%0d: got %0d want 3", i, hs_cyc[i] - hs_cyc[i-1]);
            end
        end
        total++;
        if (latch_cnt !== 16) begin
            bad++;
            $display("FAIL frame_latch_len: got %0d want 16", latch_cnt);
        end
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL frame_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_mon();
        px_ready = 1'b0;
        pulse_start();
        wait_sig(1, 50, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL bp_pix0_timeout: got %b want 1", ok);
        end
        px_ready = 1'b1;
        step();
        px_ready = 1'b0;
        wait_sig(1, 50, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL bp_pix1_timeout: got %b want 1", ok);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({px_valid, rd_en, px_data} !== {2'b10, 24'hFF0000}) begin
                bad++;
                $display("FAIL bp_hold%0d: got valid=%b rd_en=%b data=%h want 1 0 ff0000",
                         i, px_valid, rd_en, px_data);
            end
            step();
        end
        px_ready = 1'b1;
        wait_sig(0, 100, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL bp_done_timeout: got %b want 1", ok);
        end
        step();
        total++;
        if (done_cnt !== 1 || hs_q.size() !== 3) begin
            bad++;
            $display("FAIL bp_summary: got done=%0d hs=%0d want 1 3", done_cnt, hs_q.size());
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        clear_mon();
        px_ready = 1'b1;
        pulse_start();
        wait_sig(1, 50, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL ign_send_timeout: got %b want 1", ok);
        end
        pulse_start();
        wait_sig(2, 100, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL ign_latch_timeout: got %b want 1", ok);
        end
        pulse_start();
        wait_sig(0, 100, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL ign_done_timeout: got %b want 1", ok);
        end
        repeat (40) step();
        total++;
        if (done_cnt !== 1 || busy !== 1'b0 || hs_q.size() !== 3) begin
            bad++;
            $display("FAIL ign_single_frame: got done=%0d busy=%b hs=%0d want 1 0 3",
                     done_cnt, busy, hs_q.size());
        end
    endtask

    task automatic test_reset_in_latch();
        bit ok;
        clear_mon();
        px_ready = 1'b1;
        pulse_start();
        wait_sig(2, 100, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL rl_latch_timeout: got %b want 1", ok);
        end
        repeat (5) step();
        total++;
        if (latch !== 1'b1) begin
            bad++;
            $display("FAIL rl_latch_before: got %b want 1", latch);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({latch, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL rl_async_clear: got %b want 000", {latch, busy, done});
        end
        step();
        rst = 1'b0;
        repeat (30) step();
        total++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rl_no_done: got done=%0d busy=%b want 0 0", done_cnt, busy);
        end
        addr_q.delete();
        hs_q.delete();
        pulse_start();
        wait_sig(0, 200, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL rl_restart_timeout: got %b want 1", ok);
        end
        total++;
        if (addr_q.size() < 1 || addr_q[0] !== 8'h00) begin
            bad++;
            $display("FAIL rl_restart_addr: got n=%0d first=%h want 00", addr_q.size(),
                     addr_q.size() > 0 ? addr_q[0] : 8'hxx);
        end
        total++;
        if (hs_q.size() !== 3 || hs_q[0] !== exp_words[0]) begin
            bad++;
            $display("FAIL rl_restart_data: got n=%0d first=%h want 3 %h", hs_q.size(),
                     hs_q.size() > 0 ? hs_q[0] : 24'hx, exp_words[0]);
        end
        step();
    endtask

`ifdef NPX_BRIGHTNESS_EN
    task automatic test_brightness();
        bit ok;
        clear_mon();
        ram[0]     = 24'hFF8002;
        brightness = 8'd128;
        px_ready   = 1'b1;
        pulse_start();
        wait_sig(0, 200, ok);
        total++;
        if (ok !== 1'b1 || hs_q.size() !== 3 || hs_q[0] !== 24'h7F4001) begin
            bad++;
            $display("FAIL bright_scale: got ok=%b n=%0d word=%h want 1 3 7f4001", ok,
                     hs_q.size(), hs_q.size() > 0 ? hs_q[0] : 24'hx);
        end
        step();
        ram[0] = exp_words[0];
    endtask
`endif

    task automatic test_auto_refresh();
        bit ok;
        done_a_cnt = 0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_sig(3, 300, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL auto_done1_timeout: got %b want 1", ok);
        end
        step();
        total++;
        if ({rd_en_a, busy_a, rd_addr_a} !== {2'b11, 8'h00}) begin
            bad++;
            $display("FAIL auto_restart: got rd_en=%b busy=%b addr=%h want 1 1 00",
                     rd_en_a, busy_a, rd_addr_a);
        end
        wait_sig(3, 300, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL auto_done2_timeout: got %b want 1", ok);
        end
        step();
        total++;
        if (done_a_cnt !== 2) begin
            bad++;
            $display("FAIL auto_done_count: got %0d want 2", done_a_cnt);
        end
    endtask

    initial begin
        ram[0] = 24'h1F003F;
        ram[1] = 24'hFF0000;
        ram[2] = 24'h000001;
        ram[3] = 24'h000000;
        exp_words[0] = 24'h1F003F;
        exp_words[1] = 24'hFF0000;
        exp_words[2] = 24'h000001;
        test_reset();
        test_frame();
        test_backpressure();
        test_start_ignored();
        test_reset_in_latch();
`ifdef NPX_BRIGHTNESS_EN
        test_brightness();
`endif
        test_auto_refresh();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npx_frame_sched.md
NPX_FRAME_SCHED -- requirements
Module: npx_frame_sched

Interface
REQ-001 The block SHALL take parameter NUM_LEDS, default 96, as the number of pixels per frame (legal range 1..256).
REQ-002 The block SHALL take parameter LATCH_CYCLES, default 8192, as the clock count of the post-frame low (reset) gap.
REQ-003 The block SHALL take parameter AUTO_REFRESH, default 0; when 1, a new frame starts automatically after each latch gap.
REQ-004 clk  input  1  single system clock (12 MHz nominal); all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  one-cycle frame request.
REQ-007 busy  output  1  high while a frame or latch gap is in progress.
REQ-008 done  output  1  one-cycle pulse at end of latch gap.
REQ-009 rd_en  output  1  pixel RAM read strobe.
REQ-010 rd_addr  output  8  pixel RAM address.
REQ-011 rd_data  input  24  pixel RAM data (GRB order, MSB first), valid exactly one cycle after rd_en.
REQ-012 px_data  output  24  pixel word to serializer.
REQ-013 px_valid  output  1  px_data valid.
REQ-014 px_ready  input  1  serializer accepts px_data this cycle.
REQ-015 latch  output  1  high during latch gap; serializer holds line low.
REQ-016 brightness  input  8  global scale factor (used only with NPX_BRIGHTNESS_EN).

Function
REQ-017 FSM states SHALL be IDLE, FETCH, WAIT, SEND, LATCH, DONE.
REQ-018 IDLE->FETCH on start=1; rd_addr cleared to 0.
REQ-019 FETCH SHALL assert rd_en for exactly one cycle, then go to WAIT.
REQ-020 WAIT SHALL capture rd_data into px_data register and go to SEND.
REQ-021 SEND SHALL hold px_valid=1 and px_data stable until px_valid&&px_ready; px_data SHALL NOT change while valid and not ready.
REQ-022 On handshake with rd_addr<NUM_LEDS-1: rd_addr increments, next state FETCH; with rd_addr==NUM_LEDS-1: next state LATCH, rd_addr unchanged.
REQ-023 LATCH SHALL assert latch for exactly LATCH_CYCLES cycles using a counter wide enough for LATCH_CYCLES, then go to DONE.
REQ-024 DONE SHALL pulse done for one cycle; next state FETCH (rd_addr=0) if AUTO_REFRESH=1 or start=1 that cycle, else IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 start asserted in any state other than IDLE or DONE SHALL be ignored (no queueing).
REQ-027 Pixel-to-pixel latency SHALL be 3 cycles minimum (FETCH, WAIT, SEND with immediate ready).

Reset
REQ-028 rst SHALL asynchronously force state IDLE, rd_addr=0, rd_en=0, px_valid=0, px_data=0, latch=0, done=0, busy=0, latch counter=0.
REQ-029 rst mid-frame SHALL abandon the frame; no done pulse; next frame restarts at address 0.

Configuration
REQ-030 With NPX_BRIGHTNESS_EN defined, each 8-bit channel SHALL be replaced in WAIT by (channel*brightness)>>8, truncated to 8 bits, brightness sampled in the same cycle; brightness=255 yields channel-(channel>0?...) per formula, brightness=0 yields 0.
REQ-031 Without NPX_BRIGHTNESS_EN, px_data SHALL equal rd_data unchanged and brightness SHALL be unused.

Structure
REQ-032 FSM state enum, channel width (8), pixel width (24) SHALL live in shared package npx_pkg.
REQ-033 Optional sub-module npx_scale (one channel multiply-shift, combinational) SHALL be instantiated three times only under NPX_BRIGHTNESS_EN.

Verification
REQ-034 NUM_LEDS=3, LATCH_CYCLES=16, RAM {0x1F003F,0xFF0000,0x000001}, px_ready=1 -> three handshakes with those words in order, then latch high 16 cycles, done one pulse.
REQ-035 px_ready held 0 for 10 cycles during pixel 1 -> px_valid and px_data=0xFF0000 stable all 10 cycles, rd_en not reasserted.
REQ-036 start pulsed during SEND -> ignored; exactly one done per frame.
REQ-037 rst asserted in LATCH after 5 cycles -> latch=0, busy=0 immediately; no done; next start reads address 0.
REQ-038 AUTO_REFRESH=1 -> after done, rd_en with rd_addr=0 next cycle, continuous frames.
REQ-039 NPX_BRIGHTNESS_EN, brightness=128, RAM 0xFF8002 -> px_data=0x7F4001.
